// File: rtl/prbs4_if.sv
// Word/status bundle between an upstream PRBS source and the prbs4 checker.
interface prbs4_if #(parameter int ERRW = 16);
  logic            valid;
  logic [3:0]      din;
  logic            clr_err;
  logic            locked;
  logic            err_pulse;
  logic            sync_lost;
  logic [ERRW-1:0] err_cnt;

  modport master (output valid, din, clr_err,
                  input  locked, err_pulse, sync_lost, err_cnt);
  modport slave  (input  valid, din, clr_err,
                  output locked, err_pulse, sync_lost, err_cnt);
endinterface

// File: rtl/prbs4_checker.sv
// PRBS4 checker: seeds from the stream, verifies LOCK_CNT matches, then flywheels
// on its own prediction and counts mismatches until MISS_MAX in a row drop sync.
module prbs4_checker #(
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 3,
  parameter int ERRW     = 16
) (
  input logic     clk,
  input logic     reset,
  prbs4_if.slave  bus
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [3:0]      LOCK_C  = 4'(LOCK_CNT);
  localparam logic [3:0]      MISS_C  = 4'(MISS_MAX);
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_pred, w_pred_nxt;
  logic [3:0]      r_match, w_match_nxt;
  logic [3:0]      r_miss, w_miss_nxt;
  logic [ERRW-1:0] r_err_cnt, w_err_nxt;
  logic            r_locked, r_err_pulse, r_sync_lost;
  logic            w_err_pulse_nxt, w_sync_lost_nxt;

  function automatic logic [3:0] nxt(input logic [3:0] w);
    return {w[1] ^ w[0], w[3:1]};
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_pred_nxt      = r_pred;
    w_match_nxt     = r_match;
    w_miss_nxt      = r_miss;
    w_err_nxt       = r_err_cnt;
    w_err_pulse_nxt = 1'b0;
    w_sync_lost_nxt = 1'b0;
    if (bus.valid) begin
      case (r_state)
        SEARCH: begin
          // 0000 is the LFSR lock-up word and can never seed
          if (bus.din != 4'd0) begin
            w_pred_nxt  = nxt(bus.din);
            w_match_nxt = 4'd0;
            w_state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (bus.din == r_pred) begin
            w_pred_nxt = nxt(bus.din);
            if (r_match + 4'd1 == LOCK_C) begin
              w_state_nxt = LOCKED;
              w_match_nxt = 4'd0;
              w_miss_nxt  = 4'd0;
            end else begin
              w_match_nxt = r_match + 4'd1;
            end
          end else if (bus.din != 4'd0) begin
            w_pred_nxt  = nxt(bus.din);
            w_match_nxt = 4'd0;
          end else begin
            w_state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          w_pred_nxt = nxt(r_pred);
          if (bus.din == r_pred) begin
            w_miss_nxt = 4'd0;
          end else begin
            w_err_pulse_nxt = 1'b1;
            if (r_err_cnt != ERR_MAX) w_err_nxt = r_err_cnt + 1'b1;
            if (r_miss + 4'd1 == MISS_C) begin
              w_state_nxt     = SEARCH;
              w_sync_lost_nxt = 1'b1;
              w_miss_nxt      = 4'd0;
            end else begin
              w_miss_nxt = r_miss + 4'd1;
            end
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
    if (bus.clr_err) w_err_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= SEARCH;
      r_pred      <= 4'b0001;
      r_match     <= 4'd0;
      r_miss      <= 4'd0;
      r_err_cnt   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_sync_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pred      <= w_pred_nxt;
      r_match     <= w_match_nxt;
      r_miss      <= w_miss_nxt;
      r_err_cnt   <= w_err_nxt;
      r_locked    <= (w_state_nxt == LOCKED);
      r_err_pulse <= w_err_pulse_nxt;
      r_sync_lost <= w_sync_lost_nxt;
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_err_pulse;
  assign bus.sync_lost = r_sync_lost;
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_prbs4_checker.sv
// Directed bench for prbs4_checker: default instance plus a narrow-counter instance.
module tb_prbs4_checker;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  prbs4_if #(.ERRW(16)) ifa ();
  prbs4_if #(.ERRW(2))  ifb ();

  prbs4_checker #(.LOCK_CNT(4), .MISS_MAX(3),  .ERRW(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  prbs4_checker #(.LOCK_CNT(4), .MISS_MAX(15), .ERRW(2))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive one cycle on instance sel (0=a, 1=b), other idle; return #1 after the edge
  task automatic step(input bit sel, input logic v, input logic [3:0] d, input logic c);
    ifa.valid = 1'b0; ifa.din = 4'd0; ifa.clr_err = 1'b0;
    ifb.valid = 1'b0; ifb.din = 4'd0; ifb.clr_err = 1'b0;
    if (!sel) begin ifa.valid = v; ifa.din = d; ifa.clr_err = c; end
    else      begin ifb.valid = v; ifb.din = d; ifb.clr_err = c; end
    @(posedge clk);
    #1;
  endtask

  task automatic chka(input string tag, input int lk, input int ep, input int sl, input int ec);
    chk({tag, ".a.locked"},    int'(ifa.locked),    lk);
    chk({tag, ".a.err_pulse"}, int'(ifa.err_pulse), ep);
    chk({tag, ".a.sync_lost"}, int'(ifa.sync_lost), sl);
    chk({tag, ".a.err_cnt"},   int'(ifa.err_cnt),   ec);
  endtask

  task automatic chkb(input string tag, input int lk, input int ep, input int sl, input int ec);
    chk({tag, ".b.locked"},    int'(ifb.locked),    lk);
    chk({tag, ".b.err_pulse"}, int'(ifb.err_pulse), ep);
    chk({tag, ".b.sync_lost"}, int'(ifb.sync_lost), sl);
    chk({tag, ".b.err_cnt"},   int'(ifb.err_cnt),   ec);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq [5];
    logic [3:0] tail [4];
    seq  = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9};
    tail = '{4'h8, 4'h4, 4'h2, 4'h9};

    // reset state, with a mismatching word on the inputs
    reset = 1'b0;
    step(0, 1'b1, 4'h7, 1'b1);
    step(0, 1'b1, 4'h7, 1'b0);
    chka("rst", 0, 0, 0, 0);
    chkb("rst", 0, 0, 0, 0);
    reset = 1'b1;

    // 0000 in SEARCH is ignored
    step(0, 1'b1, 4'h0, 1'b0);
    chka("zero", 0, 0, 0, 0);

    // lock acquisition with bubbles between words
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b1, seq[i], 1'b0);
      chka($sformatf("gap.w%0d", i), int'(i == 4), 0, 0, 0);
      step(0, 1'b0, 4'hF, 1'b0);
      chka($sformatf("gap.b%0d", i), int'(i == 4), 0, 0, 0);
    end

    // single error while expecting 1100, then back on track
    step(0, 1'b1, 4'hF, 1'b0); chka("err1", 1, 1, 0, 1);
    step(0, 1'b1, 4'h6, 1'b0); chka("err2", 1, 0, 0, 1);
    step(0, 1'b1, 4'hB, 1'b0); chka("err3", 1, 0, 0, 1);

    // expecting 0101: one miss, a match (1010) clears the miss run, then clear count
    step(0, 1'b1, 4'h0, 1'b0); chka("miss1", 1, 1, 0, 2);
    step(0, 1'b1, 4'hA, 1'b0); chka("miss2", 1, 0, 0, 2);
    step(0, 1'b0, 4'h0, 1'b1); chka("clr",   1, 0, 0, 0);

    // three consecutive misses drop sync
    step(0, 1'b1, 4'h0, 1'b0); chka("los1", 1, 1, 0, 1);
    step(0, 1'b1, 4'h0, 1'b0); chka("los2", 1, 1, 0, 2);
    step(0, 1'b1, 4'h0, 1'b0); chka("los3", 0, 1, 1, 3);
    step(0, 1'b0, 4'h0, 1'b0); chka("los4", 0, 0, 0, 3);

    // 1000 reseeds; three matches are not enough, the fourth locks
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, tail[i], 1'b0);
      chka($sformatf("rsd%0d", i), 0, 0, 0, 3);
    end
    step(0, 1'b1, 4'hC, 1'b0); chka("rsd.lock", 1, 0, 0, 3);

    // reset mid-lock with a mismatching word present
    reset = 1'b0;
    step(0, 1'b1, 4'h3, 1'b0); chka("rstl", 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, tail[i], 1'b0);
      chka($sformatf("rel%0d", i), 0, 0, 0, 0);
    end
    step(0, 1'b1, 4'hC, 1'b0); chka("rel.lock", 1, 0, 0, 0);

    // narrow counter: lock, five misses saturate at 3, clear wins over a miss
    for (int i = 0; i < 5; i++) begin
      step(1, 1'b1, seq[i], 1'b0);
      chkb($sformatf("blk%0d", i), int'(i == 4), 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 1'b1, 4'h0, 1'b0);
      chkb($sformatf("sat%0d", i), 1, 1, 0, (i < 3) ? i + 1 : 3);
    end
    step(1, 1'b1, 4'h0, 1'b1); chkb("clrmiss", 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/prbs4_checker.md
PRBS4_CHECKER -- requirements
Module: prbs4_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive correct words required after seeding before lock is declared (range 1..15).
REQ-002 Parameter MISS_MAX, default 3: consecutive mismatches while locked that force loss of sync (range 1..15).
REQ-003 Parameter ERRW, default 16: width of the error counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 valid  input  1  din carries a word this cycle.
REQ-007 din  input  4  received 4-bit PRBS state word from the upstream lfsr4 generator.
REQ-008 clr_err  input  1  synchronous clear of err_cnt.
REQ-009 locked  output  1  checker is in LOCKED state.
REQ-010 err_pulse  output  1  one-cycle flag: the previous accepted word mismatched while locked.
REQ-011 sync_lost  output  1  one-cycle flag: lock dropped on the previous edge.
REQ-012 err_cnt  output  ERRW  saturating count of locked-state mismatches.

Function
REQ-013 The next-word function SHALL be nxt(w) = {w[1]^w[0], w[3:1]}, matching the upstream generator.
REQ-014 States SHALL be SEARCH, VERIFY and LOCKED, plus a predicted-word register pred[3:0], a match counter and a miss counter.
REQ-015 Cycles with valid=0 SHALL change no state, counter or pred; err_pulse and sync_lost SHALL be 0 in the following cycle.
REQ-016 SEARCH, valid=1, din!=0: pred<=nxt(din), match counter<=0, go to VERIFY.
REQ-017 SEARCH, valid=1, din==0: remain in SEARCH, because 0000 is an illegal (lock-up) word.
REQ-018 VERIFY, valid=1, din==pred: pred<=nxt(din), match counter +1; on the LOCK_CNT-th consecutive match go to LOCKED and clear the miss counter.
REQ-019 VERIFY, valid=1, din!=pred, din!=0: reseed with pred<=nxt(din), clear the match counter, remain in VERIFY.
REQ-020 VERIFY, valid=1, din!=pred, din==0: go to SEARCH.
REQ-021 LOCKED, valid=1: pred<=nxt(pred), so the checker flywheels on its own prediction and does not reseed from din.
REQ-022 LOCKED, valid=1, din==pred: clear the miss counter.
REQ-023 LOCKED, valid=1, din!=pred: on the same edge, set err_pulse<=1 for one cycle, increment err_cnt and increment the miss counter.
REQ-024 err_cnt SHALL saturate at 2^ERRW-1 and never wrap.
REQ-025 When the miss counter reaches MISS_MAX, on the same edge: go to SEARCH, sync_lost<=1 for one cycle, locked<=0, clear the miss counter.
REQ-026 All outputs SHALL be registered, so locked, err_pulse and sync_lost reflect the edge that accepted the word.
REQ-027 If clr_err=1 coincides with a mismatch, clr_err SHALL win: err_cnt<=0 while err_pulse still asserts.
REQ-028 clr_err SHALL NOT affect state, pred or the lock status.

Reset
REQ-029 On reset=0 at a rising edge, the following SHALL apply regardless of other inputs: state<=SEARCH, pred<=4'b0001, counters<=0, locked=0, err_pulse=0, sync_lost=0, err_cnt=0.
REQ-030 Reset asserted in any state, including mid-VERIFY or LOCKED, SHALL discard all progress; the first valid word after release is treated as a SEARCH seed.

Verification
REQ-031 Lock acquisition: LOCK_CNT=4, send 0001,1000,0100,0010,1001 with valid=1 on consecutive cycles -> locked=1 in the cycle after 1001 is accepted, err_cnt=0.
REQ-032 Single error: while locked and expecting 1100, send 1111, then 0110,1011 -> err_pulse high for exactly one cycle, err_cnt=1, locked stays 1.
REQ-033 Loss of sync: MISS_MAX=3, three consecutive wrong words while locked -> sync_lost one-cycle pulse, locked=0, err_cnt=3; next 1000 reseeds into VERIFY.
REQ-034 Gaps and zero: 0000 in SEARCH -> no transition; valid=0 bubbles inserted between the REQ-031 words -> same lock result with no spurious pulses.
REQ-035 Saturation and clear: ERRW=2, send five mismatches with MISS_MAX=15 -> err_cnt holds 3; clr_err with a mismatch -> err_cnt=0, err_pulse=1.
REQ-036 Reset mid-lock: reset=0 for one cycle while locked -> all outputs 0 on the next cycle; relock requires a fresh seed plus LOCK_CNT matches.
